pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
// - Next-generation program-counter unit for the RV32 core, replacing the fixed free-running PC register.
// - Generates fetch addresses for the IF stage through a valid/ready handshake.
// - Honours pipeline stalls and branch/jump redirects from EX.
// - Parametrised reset vector, address width and step; optional small BTB for next-PC prediction.
// PARAMETERS
// - ADDR_WIDTH    32   width of PC and all address ports
// - RESET_VECTOR  0    first fetch address after reset (must be STEP-aligned)
// - STEP          4    sequential increment in bytes (power of two, >=2)
// - BTB_DEPTH     16   BTB entries (power of two); used only with PC_GEN_BTB_EN
// PORTS
// - clock                clock
// - reset                reset
// - stall_i              in   1           hold the current PC (ID/IF back-pressure)
// - fetch_ready_i        in   1           IF accepts pc_o this cycle
// - redirect_i           in   1           EX resolved branch/jump; load redirect_target_i
// - redirect_target_i    in   ADDR_WIDTH  redirect address
// - btb_update_i         in   1           write one BTB entry (EX resolution)
// - btb_update_pc_i      in   ADDR_WIDTH  PC of the resolved branch
// - btb_update_target_i  in   ADDR_WIDTH  resolved target
// - btb_update_taken_i   in   1           1 = install/overwrite entry; 0 = invalidate entry
// - pc_o                 out  ADDR_WIDTH  current fetch address
// - pc_valid_o           out  1           pc_o is a valid fetch request
// - pred_taken_o         out  1           pc_o hit a taken BTB entry; next PC is predicted
// - flush_o              out  1           one-cycle pulse: a redirect was accepted
// - misalign_o           out  1           one-cycle pulse: redirect target had nonzero low bits
// BEHAVIOUR
// - Reset: reset is synchronous, active-high, on clock. It forces:
//   - state=BOOT, pc_o=RESET_VECTOR, pc_valid_o=0, flush_o=0, misalign_o=0;
//   - all BTB valid bits cleared.
// - FSM has two states:
//   - BOOT: pc_valid_o=0 for exactly one cycle after reset deasserts, then RUN. Redirects in BOOT are still honoured.
//   - RUN:  pc_valid_o=1 continuously.
// - Advance condition is adv = pc_valid_o & fetch_ready_i & ~stall_i. next_pc is:
//   - redirect_i=1: {redirect_target_i[ADDR_WIDTH-1:log2(STEP)], zeros}. Highest priority; overrides stall and ready.
//   - else if adv and pred_taken_o: the BTB target.
//   - else if adv: pc_o+STEP, wrapping modulo 2^ADDR_WIDTH (e.g. 0xFFFFFFFC -> 0x0).
//   - else: pc_o held; all outputs stable.
// - Latency: next_pc appears on pc_o one cycle after the deciding edge. No combinational path from inputs to pc_o.
// - flush_o: asserted in the cycle after redirect_i was sampled, for exactly one cycle.
// - misalign_o: asserted in the same cycle as flush_o when low bits of the target were nonzero.
// - Back-to-back redirects: each one loads. The last sampled target wins; flush_o stays high.
// - Reset mid-operation: reset overrides redirect and stall in the same cycle.
// CONFIGURATION
// - PC_GEN_BTB_EN defined: direct-mapped BTB of BTB_DEPTH entries.
//   - Index = pc[log2(STEP)+:log2(BTB_DEPTH)]; tag = remaining upper bits; per-entry valid bit and target.
//   - Lookup on pc_o is combinational; pred_taken_o = valid & tag match.
//   - Update writes at the clock edge. A lookup to the same index in the same cycle sees the old contents.
//   - btb_update_taken_i=0 clears that entry's valid bit.
// - PC_GEN_BTB_EN undefined:
//   - no BTB storage; pred_taken_o tied 0;
//   - btb_update_* ignored; next PC is purely sequential/redirect.
// TESTING
// - Boot: reset 3 cycles, release, fetch_ready_i=1 -> pc_valid_o=0 for 1 cycle, then pc_o=0,4,8,C on consecutive cycles.
// - Stall/ready: stall_i=1 at pc_o=0x10 for 3 cycles -> pc_o holds 0x10; release -> 0x14. Same holds for fetch_ready_i=0.
// - Redirect: at pc_o=0x20, redirect_i=1, target=0x103 with stall_i=1 -> next cycle pc_o=0x100, flush_o=1, misalign_o=1; then 0x104.
// - Wrap: redirect to 0xFFFFFFFC, ready=1 -> pc_o=0xFFFFFFFC then 0x00000000.
// - Reset mid-run: reset while redirect_i=1 -> pc_o=RESET_VECTOR, pc_valid_o=0, flush_o=0 next cycle.
// - BTB (PC_GEN_BTB_EN): update pc=0x40, target=0x200, taken=1; run from 0x3C.
//   - Expect pred_taken_o=1 at 0x40, then pc_o=0x200.
//   - After update taken=0, the next pass over 0x40 is followed by 0x44.
//   - Without the macro, 0x40 is always followed by 0x44.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator: fetch-address handshake, stall/redirect handling and
// an optional direct-mapped BTB enabled by defining PC_GEN_BTB_EN.
module pc_gen #(
  parameter int unsigned            ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned            STEP         = 4,
  parameter int unsigned            BTB_DEPTH    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  fetch_ready_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_target_i,
  input  logic                  btb_update_i,
  input  logic [ADDR_WIDTH-1:0] btb_update_pc_i,
  input  logic [ADDR_WIDTH-1:0] btb_update_target_i,
  input  logic                  btb_update_taken_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  pc_valid_o,
  output logic                  pred_taken_o,
  output logic                  flush_o,
  output logic                  misalign_o
);

  localparam int unsigned OFS  = $clog2(STEP);
  localparam int unsigned IDXW = $clog2(BTB_DEPTH);
  localparam int unsigned TAGW = ADDR_WIDTH - OFS - IDXW;

  typedef enum logic {BOOT, RUN} state_t;

  state_t                state;
  logic                  adv;
  logic                  hit;
  logic [ADDR_WIDTH-1:0] btb_target;
  logic [ADDR_WIDTH-1:0] next_pc;

`ifdef PC_GEN_BTB_EN
  logic [BTB_DEPTH-1:0]  btb_valid;
  logic [TAGW-1:0]       btb_tag [BTB_DEPTH];
  logic [ADDR_WIDTH-1:0] btb_tgt [BTB_DEPTH];
  logic [IDXW-1:0]       rd_idx;
  logic [IDXW-1:0]       wr_idx;
  logic [TAGW-1:0]       rd_tag;
  logic [TAGW-1:0]       wr_tag;
  logic                  unused_btb_low;

  assign rd_idx         = pc_o[OFS +: IDXW];
  assign rd_tag         = pc_o[ADDR_WIDTH-1 : OFS+IDXW];
  assign wr_idx         = btb_update_pc_i[OFS +: IDXW];
  assign wr_tag         = btb_update_pc_i[ADDR_WIDTH-1 : OFS+IDXW];
  assign unused_btb_low = ^btb_update_pc_i[OFS-1:0];

  // Lookup reads the array before this edge's update lands, so a same-index
  // update is only visible from the following cycle.
  assign hit        = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
  assign btb_target = btb_tgt[rd_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      btb_valid <= '0;
    end else if (btb_update_i) begin
      btb_valid[wr_idx] <= btb_update_taken_i;
    end
  end

  always_ff @(posedge clock) begin
    if (btb_update_i && btb_update_taken_i) begin
      btb_tag[wr_idx] <= wr_tag;
      btb_tgt[wr_idx] <= btb_update_target_i;
    end
  end
`else
  logic            unused_btb;
  logic [IDXW-1:0] unused_btb_idx;

  assign unused_btb     = ^{btb_update_i, btb_update_pc_i, btb_update_target_i,
                            btb_update_taken_i};
  assign unused_btb_idx = btb_update_pc_i[OFS +: IDXW];
  assign hit            = 1'b0;
  assign btb_target     = '0;
`endif

  assign pred_taken_o = hit;

  always_comb begin
    adv     = pc_valid_o & fetch_ready_i & ~stall_i;
    next_pc = pc_o;
    if (redirect_i) begin
      next_pc = {redirect_target_i[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
    end else if (adv && hit) begin
      next_pc = btb_target;
    end else if (adv) begin
      next_pc = pc_o + ADDR_WIDTH'(STEP);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= BOOT;
      pc_o       <= RESET_VECTOR;
      pc_valid_o <= 1'b0;
      flush_o    <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      pc_o       <= next_pc;
      flush_o    <= redirect_i;
      misalign_o <= redirect_i & (|redirect_target_i[OFS-1:0]);
      case (state)
        BOOT: begin
          state      <= RUN;
          pc_valid_o <= 1'b1;
        end
        RUN: begin
          pc_valid_o <= 1'b1;
        end
        default: begin
          state      <= BOOT;
          pc_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, BTB sequence and
// randomized run against a behavioural next-PC model.
module tb_pc_gen;

`ifdef PC_GEN_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        stall_i;
  logic        fetch_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic        btb_update_i;
  logic [31:0] btb_update_pc_i;
  logic [31:0] btb_update_target_i;
  logic        btb_update_taken_i;
  logic [31:0] pc_o;
  logic        pc_valid_o;
  logic        pred_taken_o;
  logic        flush_o;
  logic        misalign_o;

  int n_checks = 0;
  int n_fail   = 0;

  pc_gen #(
    .ADDR_WIDTH  (32),
    .RESET_VECTOR(32'h0),
    .STEP        (4),
    .BTB_DEPTH   (16)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .stall_i            (stall_i),
    .fetch_ready_i      (fetch_ready_i),
    .redirect_i         (redirect_i),
    .redirect_target_i  (redirect_target_i),
    .btb_update_i       (btb_update_i),
    .btb_update_pc_i    (btb_update_pc_i),
    .btb_update_target_i(btb_update_target_i),
    .btb_update_taken_i (btb_update_taken_i),
    .pc_o               (pc_o),
    .pc_valid_o         (pc_valid_o),
    .pred_taken_o       (pred_taken_o),
    .flush_o            (flush_o),
    .misalign_o         (misalign_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: PC, flags and a table of remembered branches indexed by
  // word address modulo 16, matched on the address bits above that window.
  bit [31:0] m_pc;
  bit        m_valid, m_flush, m_mis;
  bit        m_bv  [16];
  bit [31:0] m_bpc [16];
  bit [31:0] m_bt  [16];

  function automatic bit m_hit(input bit [31:0] pc);
    int unsigned slot = (pc / 4) % 16;
    return m_bv[slot] && ((m_bpc[slot] / 64) == (pc / 64));
  endfunction

  task automatic model_edge();
    bit        pred;
    int unsigned slot;
    pred = BTB_ON && m_hit(m_pc);
    if (reset) begin
      m_pc = 32'h0; m_valid = 0; m_flush = 0; m_mis = 0;
      for (int i = 0; i < 16; i++) m_bv[i] = 0;
    end else begin
      if (redirect_i)
        m_pc = (redirect_target_i / 4) * 4;
      else if (m_valid && fetch_ready_i && !stall_i)
        m_pc = pred ? m_bt[(m_pc / 4) % 16] : m_pc + 32'd4;
      m_flush = redirect_i;
      m_mis   = redirect_i && (redirect_target_i % 4 != 0);
      m_valid = 1;
      if (btb_update_i) begin
        slot = (btb_update_pc_i / 4) % 16;
        m_bv[slot] = btb_update_taken_i;
        if (btb_update_taken_i) begin
          m_bpc[slot] = btb_update_pc_i;
          m_bt[slot]  = btb_update_target_i;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, stall, rdy, redir;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_v, e_f, e_m;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, stall, rdy, redir, input logic [31:0] tgt,
                              input logic [31:0] e_pc, input logic e_v, e_f, e_m);
    vec_t v;
    v.rst = rst; v.stall = stall; v.rdy = rdy; v.redir = redir; v.tgt = tgt;
    v.e_pc = e_pc; v.e_v = e_v; v.e_f = e_f; v.e_m = e_m;
    return v;
  endfunction

  task automatic set_btb(input logic upd, input logic [31:0] upc, utgt, input logic taken);
    btb_update_i = upd; btb_update_pc_i = upc;
    btb_update_target_i = utgt; btb_update_taken_i = taken;
  endtask

  initial begin
    reset = 1; stall_i = 0; fetch_ready_i = 0; redirect_i = 0; redirect_target_i = '0;
    set_btb(0, 0, 0, 0);

    //           rst st rdy rd tgt           pc            v  f  m
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,        32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,        32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0,        32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        32'h0,        1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        32'h4,        1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        32'h8,        1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        32'hC,        1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        32'h10,       1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,        32'h10,       1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,        32'h10,       1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,        32'h10,       1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        32'h14,       1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h14,       1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,        32'h14,       1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        32'h18,       1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        32'h1C,       1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        32'h20,       1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 32'h103,      32'h100,      1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        32'h104,      1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h200,      32'h200,      1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'h301,      32'h300,      1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        32'h0,        1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        32'h4,        1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 32'h500,      32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h600,      32'h600,      1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,        32'h604,      1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; stall_i = tbl[i].stall; fetch_ready_i = tbl[i].rdy;
      redirect_i = tbl[i].redir; redirect_target_i = tbl[i].tgt;
      tick();
      chk($sformatf("vec%0d pc", i),    pc_o,               tbl[i].e_pc);
      chk($sformatf("vec%0d valid", i), 32'(pc_valid_o),    32'(tbl[i].e_v));
      chk($sformatf("vec%0d flush", i), 32'(flush_o),       32'(tbl[i].e_f));
      chk($sformatf("vec%0d mis", i),   32'(misalign_o),    32'(tbl[i].e_m));
      chk($sformatf("vec%0d pred", i),  32'(pred_taken_o),  32'h0);
    end

    // Branch prediction pass over 0x40, then invalidate and pass again.
    reset = 1; redirect_i = 0; stall_i = 0; fetch_ready_i = 1;
    tick();
    reset = 0; redirect_i = 1; redirect_target_i = 32'h3C;
    set_btb(1, 32'h40, 32'h200, 1);
    tick();
    chk("btb start pc", pc_o, 32'h3C);
    redirect_i = 0; set_btb(0, 0, 0, 0);
    tick();
    chk("btb at 0x40 pc", pc_o, 32'h40);
    chk("btb at 0x40 pred", 32'(pred_taken_o), 32'(BTB_ON));
    tick();
    chk("btb after 0x40", pc_o, BTB_ON ? 32'h200 : 32'h44);
    redirect_i = 1; redirect_target_i = 32'h3C;
    set_btb(1, 32'h40, 32'h200, 0);
    tick();
    chk("btb inval pc", pc_o, 32'h3C);
    redirect_i = 0; set_btb(0, 0, 0, 0);
    tick();
    chk("btb inval pred", 32'(pred_taken_o), 32'h0);
    tick();
    chk("btb inval next", pc_o, 32'h44);

    // Randomized run against the model.
    reset = 1; tick(); reset = 0;
    for (int c = 0; c < 2000; c++) begin
      reset         = ($urandom_range(0, 99) == 0);
      stall_i       = ($urandom_range(0, 3) == 0);
      fetch_ready_i = ($urandom_range(0, 3) != 0);
      redirect_i    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) redirect_target_i = 32'hFFFFFFF0 + $urandom_range(0, 15);
      else                           redirect_target_i = $urandom_range(0, 127);
      set_btb($urandom_range(0, 3) == 0, $urandom_range(0, 31) * 4,
              $urandom_range(0, 31) * 4, $urandom_range(0, 3) != 0);
      tick();
      chk("rnd pc",    pc_o,               m_pc);
      chk("rnd valid", 32'(pc_valid_o),    32'(m_valid));
      chk("rnd flush", 32'(flush_o),       32'(m_flush));
      chk("rnd mis",   32'(misalign_o),    32'(m_mis));
      chk("rnd pred",  32'(pred_taken_o),  32'(BTB_ON && m_hit(m_pc)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
